// File: rtl/miriscv_gpr_wb.sv
// Writeback and hazard unit in front of the GPR file: merges single-cycle and
// long-latency results into one write port and tracks pending destinations.
module miriscv_gpr_wb #(
  parameter int XLEN           = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int LONG_DEPTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,

  input  logic                      issue_valid_i,
  input  logic                      issue_long_i,
  input  logic                      issue_rd_we_i,
  input  logic [GPR_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [GPR_ADDR_WIDTH-1:0] issue_rs1_i,
  input  logic [GPR_ADDR_WIDTH-1:0] issue_rs2_i,
  output logic                      issue_stall_o,

  input  logic                      ex_valid_i,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic [XLEN-1:0]           ex_data_i,

  input  logic                      long_rsp_valid_i,
  input  logic [XLEN-1:0]           long_rsp_data_i,
  output logic                      long_rsp_ready_o,

  output logic                      gpr_wr_en_o,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
  output logic [XLEN-1:0]           gpr_wr_data_o,
  output logic                      busy_o
);

  localparam int NUM_REGS = 2 ** GPR_ADDR_WIDTH;
  localparam int PTR_W    = (LONG_DEPTH > 1) ? $clog2(LONG_DEPTH) : 1;
  localparam int CNT_W    = $clog2(LONG_DEPTH + 1);

  localparam logic [PTR_W-1:0]          LAST_PTR = PTR_W'(LONG_DEPTH - 1);
  localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(LONG_DEPTH);
  localparam logic [GPR_ADDR_WIDTH-1:0] X0       = '0;

  logic [NUM_REGS-1:0]       pending;
  logic [GPR_ADDR_WIDTH-1:0] tag_mem [LONG_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_count;

  logic                      hold_valid;
  logic [GPR_ADDR_WIDTH-1:0] hold_rd;
  logic [XLEN-1:0]           hold_data;

  logic                      fifo_full;
  logic                      hazard;
  logic                      push;
  logic                      accept;
  logic                      hold_drain;
  logic [GPR_ADDR_WIDTH-1:0] push_tag;

  assign fifo_full  = (fifo_count == FULL_CNT);
  assign hazard     = pending[issue_rs1_i] | pending[issue_rs2_i]
                    | (issue_rd_we_i & pending[issue_rd_i])
                    | (issue_long_i & fifo_full);
  assign issue_stall_o = issue_valid_i & hazard;

  assign push     = issue_valid_i & issue_long_i & ~issue_stall_o;
  // Non-writing long ops still occupy a slot so responses stay in order.
  assign push_tag = issue_rd_we_i ? issue_rd_i : X0;

  assign hold_drain       = hold_valid & ~ex_valid_i;
  assign long_rsp_ready_o = (fifo_count != '0) & (~hold_valid | hold_drain);
  assign accept           = long_rsp_valid_i & long_rsp_ready_o;
  assign busy_o           = (fifo_count != '0) | hold_valid;

  // Execute results win the port; the hold entry waits for a free cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    gpr_wr_en_o   = 1'b0;
    gpr_wr_addr_o = hold_rd;
    gpr_wr_data_o = hold_data;
    if (ex_valid_i) begin
      gpr_wr_en_o   = (ex_rd_i != X0);
      gpr_wr_addr_o = ex_rd_i;
      gpr_wr_data_o = ex_data_i;
    end else if (hold_drain) begin
      gpr_wr_en_o   = (hold_rd != X0);
    end
  end

  // NOTE: tag storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update from the same pre-edge values.
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else begin
      // Clear before set; the WAW stall keeps both from hitting one bit.
      if (hold_drain) pending[hold_rd] <= 1'b0;
      if (push && issue_rd_we_i && (issue_rd_i != X0)) pending[issue_rd_i] <= 1'b1;

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (accept) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

      case ({push, accept})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (accept) begin
        hold_valid <= 1'b1;
        hold_rd    <= tag_mem[rd_ptr];
        hold_data  <= long_rsp_data_i;
      end else if (hold_drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_gpr_wb.sv
// Directed bench for miriscv_gpr_wb: reset, long writeback, hazards,
// ex-path priority, FIFO-full stall, back-to-back responses, mid-op reset.
module tb_miriscv_gpr_wb;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        issue_valid_i, issue_long_i, issue_rd_we_i;
  logic [4:0]  issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic        issue_stall_o;
  logic        ex_valid_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_data_i;
  logic        long_rsp_valid_i;
  logic [31:0] long_rsp_data_i;
  logic        long_rsp_ready_o;
  logic        gpr_wr_en_o;
  logic [4:0]  gpr_wr_addr_o;
  logic [31:0] gpr_wr_data_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  miriscv_gpr_wb #(.XLEN(32), .GPR_ADDR_WIDTH(5), .LONG_DEPTH(2)) dut (
    .clk_i            (clk_i),
    .arstn_i          (arstn_i),
    .issue_valid_i    (issue_valid_i),
    .issue_long_i     (issue_long_i),
    .issue_rd_we_i    (issue_rd_we_i),
    .issue_rd_i       (issue_rd_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_rs2_i      (issue_rs2_i),
    .issue_stall_o    (issue_stall_o),
    .ex_valid_i       (ex_valid_i),
    .ex_rd_i          (ex_rd_i),
    .ex_data_i        (ex_data_i),
    .long_rsp_valid_i (long_rsp_valid_i),
    .long_rsp_data_i  (long_rsp_data_i),
    .long_rsp_ready_o (long_rsp_ready_o),
    .gpr_wr_en_o      (gpr_wr_en_o),
    .gpr_wr_addr_o    (gpr_wr_addr_o),
    .gpr_wr_data_o    (gpr_wr_data_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    issue_long_i     = 1'b0;
    issue_rd_we_i    = 1'b0;
    issue_rd_i       = '0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    ex_valid_i       = 1'b0;
    ex_rd_i          = '0;
    ex_data_i        = '0;
    long_rsp_valid_i = 1'b0;
    long_rsp_data_i  = '0;
  endtask

  task automatic issue(input logic lng, input logic we, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid_i = 1'b1;
    issue_long_i  = lng;
    issue_rd_we_i = we;
    issue_rd_i    = rd;
    issue_rs1_i   = rs1;
    issue_rs2_i   = rs2;
  endtask

  task automatic rsp(input logic [31:0] data);
    long_rsp_valid_i = 1'b1;
    long_rsp_data_i  = data;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_en"},   32'(gpr_wr_en_o), 32'h1);
    check({tag, "_addr"}, 32'(gpr_wr_addr_o), 32'(addr));
    check({tag, "_data"}, gpr_wr_data_o, data);
  endtask

  initial begin
    idle();
    arstn_i = 1'b0;
    #2;
    check("rst_stall", 32'(issue_stall_o), 32'h0);
    check("rst_ready", 32'(long_rsp_ready_o), 32'h0);
    check("rst_wr_en", 32'(gpr_wr_en_o), 32'h0);
    check("rst_busy",  32'(busy_o), 32'h0);
    #10 arstn_i = 1'b1;
    tick();

    // Long load to x5, dependent instruction stalls until after the write
    issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    #1 check("ld5_issue_stall", 32'(issue_stall_o), 32'h0);
    tick();
    idle();
    issue(1'b0, 1'b1, 5'd10, 5'd5, 5'd0);
    #1 check("raw5_stall", 32'(issue_stall_o), 32'h1);
    check("ld5_busy", 32'(busy_o), 32'h1);
    tick();
    tick();
    rsp(32'hDEADBEEF);
    #1 check("ld5_ready", 32'(long_rsp_ready_o), 32'h1);
    check("raw5_stall_rsp", 32'(issue_stall_o), 32'h1);
    tick();
    long_rsp_valid_i = 1'b0;
    #1 check_wr("ld5_wr", 5'd5, 32'hDEADBEEF);
    check("raw5_stall_wr", 32'(issue_stall_o), 32'h1);
    tick();
    check("raw5_release", 32'(issue_stall_o), 32'h0);
    check("ld5_wr_done", 32'(gpr_wr_en_o), 32'h0);
    check("ld5_busy_done", 32'(busy_o), 32'h0);
    idle();

    // Long op targeting x0: no pending, no GPR write
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_issue_stall", 32'(issue_stall_o), 32'h0);
    tick();
    idle();
    issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    rsp(32'h00001234);
    #1 check("x0_dep_stall", 32'(issue_stall_o), 32'h0);
    check("x0_ready", 32'(long_rsp_ready_o), 32'h1);
    tick();
    idle();
    #1 check("x0_no_wr", 32'(gpr_wr_en_o), 32'h0);
    check("x0_busy_hold", 32'(busy_o), 32'h1);
    tick();
    check("x0_busy_done", 32'(busy_o), 32'h0);

    // Hold for x7 blocked by two ex cycles; x8 response waits meanwhile
    issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 5'd8, 5'd0, 5'd0);
    tick();
    idle();
    rsp(32'h00000077);
    #1 check("x7_ready", 32'(long_rsp_ready_o), 32'h1);
    tick();
    ex_valid_i = 1'b1;
    ex_rd_i    = 5'd3;
    ex_data_i  = 32'h00000011;
    rsp(32'h00000088);
    for (int i = 0; i < 2; i++) begin
      #1 check("ex_blk_ready", 32'(long_rsp_ready_o), 32'h0);
      check_wr("ex_x3", 5'd3, 32'h00000011);
      tick();
    end
    ex_valid_i = 1'b0;
    #1 check_wr("x7_wr", 5'd7, 32'h00000077);
    check("x8_ready_drain", 32'(long_rsp_ready_o), 32'h1);
    tick();
    long_rsp_valid_i = 1'b0;
    #1 check_wr("x8_wr", 5'd8, 32'h00000088);
    tick();
    check("x8_busy_done", 32'(busy_o), 32'h0);

    // FIFO full stall, then three back-to-back responses
    issue(1'b1, 1'b1, 5'd1, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 5'd2, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    #1 check("full_stall", 32'(issue_stall_o), 32'h1);
    rsp(32'h0000000A);
    #1 check("full_ready_a", 32'(long_rsp_ready_o), 32'h1);
    check("full_stall_rsp", 32'(issue_stall_o), 32'h1);
    tick();
    rsp(32'h0000000B);
    #1 check("full_release", 32'(issue_stall_o), 32'h0);
    check_wr("x1_wr", 5'd1, 32'h0000000A);
    check("b2b_ready_b", 32'(long_rsp_ready_o), 32'h1);
    tick();
    issue_valid_i = 1'b0;
    rsp(32'h0000000C);
    #1 check_wr("x2_wr", 5'd2, 32'h0000000B);
    check("b2b_ready_c", 32'(long_rsp_ready_o), 32'h1);
    tick();
    idle();
    #1 check_wr("x9_wr", 5'd9, 32'h0000000C);
    tick();
    check("b2b_busy_done", 32'(busy_o), 32'h0);

    // Reset with two tags outstanding
    issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    issue(1'b1, 1'b1, 5'd6, 5'd0, 5'd0);
    tick();
    idle();
    #1 check("mid_busy", 32'(busy_o), 32'h1);
    arstn_i = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(gpr_wr_en_o), 32'h0);
    check("mid_rst_busy",  32'(busy_o), 32'h0);
    check("mid_rst_ready", 32'(long_rsp_ready_o), 32'h0);
    check("mid_rst_stall", 32'(issue_stall_o), 32'h0);
    #2 arstn_i = 1'b1;
    issue(1'b0, 1'b1, 5'd11, 5'd4, 5'd6);
    rsp(32'h00005555);
    #1 check("post_rst_stall", 32'(issue_stall_o), 32'h0);
    check("post_rst_ready", 32'(long_rsp_ready_o), 32'h0);
    tick();
    idle();
    #1 check("post_rst_wr_en", 32'(gpr_wr_en_o), 32'h0);
    check("post_rst_busy", 32'(busy_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miriscv_gpr_wb.md
Name: miriscv_gpr_wb

Overview:
- Writeback and hazard unit directly upstream of the general-purpose register file (GPR).
- Owns the GPR write port. It merges single-cycle execute results with out-of-order-in-time long-latency results (load, mul/div) into one write per cycle.
- Keeps a per-register pending scoreboard and an in-order tag FIFO of destination addresses for outstanding long operations.
- Produces the decode stall signal for RAW and WAW hazards.

Parameters:
- XLEN, 32, data width.
- GPR_ADDR_WIDTH, 5, register address width; NUM_REGS = 2**GPR_ADDR_WIDTH.
- LONG_DEPTH, 2, maximum outstanding long operations (tag FIFO depth, power of 2, ≥1).

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous reset, active-low
- issue_valid_i  in  1  decode presents an instruction
- issue_long_i  in  1  instruction's result returns later on the long_rsp path
- issue_rd_we_i  in  1  instruction writes rd
- issue_rd_i  in  GPR_ADDR_WIDTH  destination register
- issue_rs1_i  in  GPR_ADDR_WIDTH  source register 1
- issue_rs2_i  in  GPR_ADDR_WIDTH  source register 2
- issue_stall_o  out  1  instruction must be held this cycle
- ex_valid_i  in  1  single-cycle result valid (issued this same cycle, not stalled)
- ex_rd_i  in  GPR_ADDR_WIDTH  single-cycle destination
- ex_data_i  in  XLEN  single-cycle result
- long_rsp_valid_i  in  1  long-latency result valid
- long_rsp_data_i  in  XLEN  long-latency result
- long_rsp_ready_o  out  1  long result accepted this cycle
- gpr_wr_en_o  out  1  GPR write enable
- gpr_wr_addr_o  out  GPR_ADDR_WIDTH  GPR write address
- gpr_wr_data_o  out  XLEN  GPR write data
- busy_o  out  1  any long operation outstanding

Behaviour:
- Reset (async, arstn_i low) clears:
  - pending[NUM_REGS-1:0], FIFO pointers and count, hold_valid.
  - Outputs then read issue_stall_o = 0 (with issue_valid_i = 0), long_rsp_ready_o = 0, gpr_wr_en_o = 0, busy_o = 0.
  - Reset mid-operation discards all outstanding tags; later responses are not accepted until a new long issue.
- Register x0 is never marked pending and is never written. Writes addressed to x0 are consumed, not forwarded to the GPR.
- Hazard check (combinational):
  - hz = (pending[rs1] | pending[rs2] | (issue_rd_we_i & pending[rd])) | (issue_long_i & fifo_full).
  - issue_stall_o = issue_valid_i & hz.
- Long issue fires when issue_valid_i & issue_long_i & !issue_stall_o:
  - Push rd into the tag FIFO; a non-writing instruction pushes x0.
  - Set pending[rd] at the clock edge when issue_rd_we_i and rd != 0.
- Short path contract: decode asserts ex_valid_i only for non-stalled, non-long instructions. No scoreboard update on this path.
- Hold register (1 entry: hold_rd, hold_data):
  - long_rsp_ready_o = (fifo_count != 0) & (!hold_valid | hold_drain).
  - Acceptance (valid & ready): pop FIFO head into hold_rd, capture data, set hold_valid next cycle.
  - Responses return in issue order.
- Write arbitration (combinational, same cycle):
  - ex path has strict priority.
  - hold_drain = hold_valid & !ex_valid_i.
  - gpr_wr_en_o = (ex_valid_i & ex_rd_i != 0) | (hold_drain & hold_rd != 0); address and data are muxed accordingly.
  - On hold_drain, clear pending[hold_rd] and hold_valid at the edge, unless refilled by a same-cycle acceptance.
- Stall release: pending clears on the drain edge, so a dependent instruction is unstalled the cycle after the GPR write and reads the updated value. No forwarding.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - Acceptance while the hold drains keeps hold_valid = 1 (back-to-back, 1 result/cycle).
  - Set and clear of the same pending bit cannot coincide, because the WAW stall prevents it.
- Long-path latency: response accepted in cycle N → GPR write in cycle N+1 at the earliest; delayed by each cycle with ex_valid_i.
- busy_o = (fifo_count != 0) | hold_valid.
- Pointer wrap-around modulo LONG_DEPTH; full when count == LONG_DEPTH.

Test Plan:
- Reset, then issue a long load to x5; response 0xDEADBEEF 3 cycles later → ready=1 on the response cycle. Next cycle: gpr_wr_en_o=1, addr=5, data=0xDEADBEEF; pending[5] cleared; busy_o=0 after.
- Long to x5 pending; issue with rs1=x5 → issue_stall_o=1 until the cycle after the GPR write; rs1=x0 with x0 as a long rd → never stalls, no write.
- Hold valid for x7 while ex_valid_i=1 (x3, 0x11) for 2 cycles → ex writes x3 each cycle; x7 writes on the 3rd cycle; a response arriving meanwhile sees ready=0.
- LONG_DEPTH=2: issue long x1, x2, then a third long → stall until the first response is accepted; responses 0xA, 0xB written to x1, x2 in order.
- Back-to-back responses on consecutive cycles with no ex traffic → writes on consecutive cycles, ready held 1.
- Assert arstn_i with 2 tags outstanding → all outputs 0, pending cleared, a following response sees ready=0.
